// File: rtl/sdram_arbiter_if.sv
// Bus bundles used by sdram_arbiter.
//
// sdram_req_if    : requester side. Four (N_REQ) masters present level-held
//                   read/write requests with packed addresses/write data and
//                   receive one-cycle finished pulses plus a shared read-data
//                   bus.
//                   modport master -> the requesting cores
//                   modport slave  -> the arbiter
// sdram_avalon_if : Avalon-MM port of new_sdram_controller_0_s1.
//                   modport master -> the arbiter
//                   modport slave  -> the SDRAM controller

interface sdram_req_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_read;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]       req_readdata;
  logic [N_REQ-1:0]        req_read_finished;
  logic [N_REQ-1:0]        req_write_finished;

  modport master (
    output req_read, req_write, req_addr, req_writedata,
    input  req_readdata, req_read_finished, req_write_finished
  );

  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    output req_readdata, req_read_finished, req_write_finished
  );
endinterface

interface sdram_avalon_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] new_sdram_controller_0_s1_address;
  logic [3:0]        new_sdram_controller_0_s1_byteenable_n;
  logic              new_sdram_controller_0_s1_chipselect;
  logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata;
  logic              new_sdram_controller_0_s1_read_n;
  logic              new_sdram_controller_0_s1_write_n;
  logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata;
  logic              new_sdram_controller_0_s1_readdatavalid;
  logic              new_sdram_controller_0_s1_waitrequest;

  modport master (
    output new_sdram_controller_0_s1_address, new_sdram_controller_0_s1_byteenable_n,
           new_sdram_controller_0_s1_chipselect, new_sdram_controller_0_s1_writedata,
           new_sdram_controller_0_s1_read_n, new_sdram_controller_0_s1_write_n,
    input  new_sdram_controller_0_s1_readdata, new_sdram_controller_0_s1_readdatavalid,
           new_sdram_controller_0_s1_waitrequest
  );

  modport slave (
    input  new_sdram_controller_0_s1_address, new_sdram_controller_0_s1_byteenable_n,
           new_sdram_controller_0_s1_chipselect, new_sdram_controller_0_s1_writedata,
           new_sdram_controller_0_s1_read_n, new_sdram_controller_0_s1_write_n,
    output new_sdram_controller_0_s1_readdata, new_sdram_controller_0_s1_readdatavalid,
           new_sdram_controller_0_s1_waitrequest
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one Avalon-MM SDRAM controller slave among N_REQ
// masters (0 load, 1 record, 2 mix, 3 pitch). Round-robin grant, a single
// transaction in flight, one-cycle finished pulse back to the winner.
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   req           : sdram_req_if.slave   - requester strobes/data/finished
//   sdram         : sdram_avalon_if.master - controller Avalon-MM port
//   grant_id      : current / most recent granted requester
//   busy          : high whenever the FSM is not IDLE
//   timeout_err   : sticky read-timeout flag
//
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN
//   defined   -> a read waiting TIMEOUT_CYCLES cycles without readdatavalid
//                completes with data 0 and sets timeout_err.
//   undefined -> reads wait forever; timeout_err is constant 0.

module sdram_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  sdram_req_if.slave               req,
  sdram_avalon_if.master           sdram,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   last_reg, last_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic              op_read_reg, op_read_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [N_REQ-1:0]  rd_fin_reg, rd_fin_next;
  logic [N_REQ-1:0]  wr_fin_reg, wr_fin_next;
  logic              cs_reg, cs_next;
  logic              rd_n_reg, rd_n_next;
  logic              wr_n_reg, wr_n_next;
  logic [3:0]        be_n_reg, be_n_next;
  logic              busy_reg, busy_next;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
  logic              terr_reg, terr_next;
`endif

  // Unpack the per-requester address / write-data buses.
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [N_REQ-1:0]  pending;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req.req_writedata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign pending = req.req_read | req.req_write;

  // First pending index scanning last+1, last+2, ... (mod N_REQ). The last
  // winner is checked last, so nobody is served twice while others wait.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  logic [ID_W-1:0] pick;
  assign pick = rr_pick(pending, last_reg);

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    grant_next   = grant_reg;
    op_read_next = op_read_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    rd_fin_next  = '0;
    wr_fin_next  = '0;
    cs_next      = cs_reg;
    rd_n_next    = rd_n_reg;
    wr_n_next    = wr_n_reg;
    be_n_next    = be_n_reg;
`ifdef SDRAM_ARB_TIMEOUT_EN
    tcnt_next    = tcnt_reg;
    terr_next    = terr_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (|pending) begin
          // A requester asserting both strobes gets a read.
          grant_next   = pick;
          last_next    = pick;
          op_read_next = req.req_read[pick];
          addr_next    = addr_arr[pick];
          wdata_next   = wdata_arr[pick];
          cs_next      = 1'b1;
          be_n_next    = 4'h0;
          rd_n_next    = ~req.req_read[pick];
          wr_n_next    = req.req_read[pick];
          state_next   = ISSUE;
        end
      end

      ISSUE: begin
        // Strobes and latched address/data stay put while the slave stalls.
        if (!sdram.new_sdram_controller_0_s1_waitrequest) begin
          cs_next   = 1'b0;
          be_n_next = 4'hF;
          rd_n_next = 1'b1;
          wr_n_next = 1'b1;
          if (op_read_reg) begin
            state_next = WAIT_DATA;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tcnt_next  = '0;
`endif
          end else begin
            wr_fin_next[grant_reg] = 1'b1;
            state_next             = DONE;
          end
        end
      end

      WAIT_DATA: begin
        if (sdram.new_sdram_controller_0_s1_readdatavalid) begin
          rdata_next             = sdram.new_sdram_controller_0_s1_readdata;
          rd_fin_next[grant_reg] = 1'b1;
          state_next             = DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tcnt_reg == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_next             = '0;
          rd_fin_next[grant_reg] = 1'b1;
          terr_next              = 1'b1;
          state_next             = DONE;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
`endif
      end

      // Gives the requester one cycle to drop its level before re-arbitration.
      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      last_reg    <= LAST_RST;
      grant_reg   <= '0;
      op_read_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      rd_fin_reg  <= '0;
      wr_fin_reg  <= '0;
      cs_reg      <= 1'b0;
      rd_n_reg    <= 1'b1;
      wr_n_reg    <= 1'b1;
      be_n_reg    <= 4'hF;
      busy_reg    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tcnt_reg    <= '0;
      terr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      op_read_reg <= op_read_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      rd_fin_reg  <= rd_fin_next;
      wr_fin_reg  <= wr_fin_next;
      cs_reg      <= cs_next;
      rd_n_reg    <= rd_n_next;
      wr_n_reg    <= wr_n_next;
      be_n_reg    <= be_n_next;
      busy_reg    <= busy_next;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tcnt_reg    <= tcnt_next;
      terr_reg    <= terr_next;
`endif
    end
  end

  assign sdram.new_sdram_controller_0_s1_address      = addr_reg;
  assign sdram.new_sdram_controller_0_s1_byteenable_n = be_n_reg;
  assign sdram.new_sdram_controller_0_s1_chipselect   = cs_reg;
  assign sdram.new_sdram_controller_0_s1_writedata    = wdata_reg;
  assign sdram.new_sdram_controller_0_s1_read_n       = rd_n_reg;
  assign sdram.new_sdram_controller_0_s1_write_n      = wr_n_reg;

  assign req.req_readdata       = rdata_reg;
  assign req.req_read_finished  = rd_fin_reg;
  assign req.req_write_finished = wr_fin_reg;

  assign grant_id = grant_reg;
  assign busy     = busy_reg;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign timeout_err = terr_reg;
`else
  assign timeout_err = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed transactions, a scripted Avalon slave
// (configurable stall and read latency) and a scoreboard monitor that checks
// every accepted Avalon command and every finished pulse against queues the
// stimulus fills.

module tb_sdram_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_req_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rq ();
  sdram_avalon_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) av ();

  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  sdram_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .req(rq), .sdram(av),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // Short aliases for the Avalon outputs
  logic              cs, rd_n, wr_n;
  logic [3:0]        be_n;
  logic [ADDR_W-1:0] av_addr;
  logic [DATA_W-1:0] av_wdata;
  assign cs       = av.new_sdram_controller_0_s1_chipselect;
  assign rd_n     = av.new_sdram_controller_0_s1_read_n;
  assign wr_n     = av.new_sdram_controller_0_s1_write_n;
  assign be_n     = av.new_sdram_controller_0_s1_byteenable_n;
  assign av_addr  = av.new_sdram_controller_0_s1_address;
  assign av_wdata = av.new_sdram_controller_0_s1_writedata;

  typedef struct {bit is_read; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} bus_t;
  typedef struct {int idx; bit is_read; logic [DATA_W-1:0] rdata;} fin_t;
  bus_t exp_bus[$];
  fin_t exp_fin[$];

  int tests = 0;
  int fails = 0;

  // Slave configuration (written by stimulus, read by the slave model)
  int          stall_cfg   = 0;
  int          rd_lat_cfg  = 0;   // 0 = never return data
  logic [31:0] rd_data_cfg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Avalon slave model ----------------
  initial begin : slave
    int stall_cnt;
    int rdv_cnt;
    stall_cnt = 0;
    rdv_cnt   = 0;
    av.new_sdram_controller_0_s1_readdata      = '1;
    av.new_sdram_controller_0_s1_readdatavalid = 1'b0;
    av.new_sdram_controller_0_s1_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      av.new_sdram_controller_0_s1_readdatavalid = 1'b0;
      av.new_sdram_controller_0_s1_readdata      = '1;
      if (rdv_cnt > 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) begin
          av.new_sdram_controller_0_s1_readdatavalid = 1'b1;
          av.new_sdram_controller_0_s1_readdata      = rd_data_cfg;
        end
      end
      if (cs) begin
        if (stall_cnt < stall_cfg) begin
          av.new_sdram_controller_0_s1_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          av.new_sdram_controller_0_s1_waitrequest = 1'b0;
          stall_cnt = 0;
          if (!rd_n && rd_lat_cfg > 0) rdv_cnt = rd_lat_cfg;
        end
      end else begin
        av.new_sdram_controller_0_s1_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // ---------------- Scoreboard monitor ----------------
  initial begin : monitor
    bus_t             b;
    fin_t             e;
    logic [N_REQ-1:0] rdf, wrf, f;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (cs && av.new_sdram_controller_0_s1_waitrequest && exp_bus.size() > 0)
          check("stall_addr_hold", 64'(av_addr), 64'(exp_bus[0].addr));
        if (cs && !av.new_sdram_controller_0_s1_waitrequest) begin
          if (exp_bus.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_cmd: got command addr %0h, expected none", av_addr);
          end else begin
            b = exp_bus.pop_front();
            check("cmd_addr", 64'(av_addr), 64'(b.addr));
            check("cmd_rd_wr_n", 64'({rd_n, wr_n}), b.is_read ? 64'h1 : 64'h2);
            check("cmd_be_n", 64'(be_n), 64'h0);
            if (!b.is_read) check("cmd_wdata", 64'(av_wdata), 64'(b.wdata));
          end
        end
        rdf = rq.req_read_finished;
        wrf = rq.req_write_finished;
        f   = rdf | wrf;
        if (f != '0) begin
          check("fin_onehot", 64'($onehot(f)), 64'h1);
          check("fin_not_both", 64'((rdf != '0) && (wrf != '0)), 64'h0);
          if (exp_fin.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_fin: got rd %b wr %b, expected none", rdf, wrf);
          end else begin
            e = exp_fin.pop_front();
            check("fin_vector", 64'(f), 64'(1) << e.idx);
            check("fin_is_read", 64'(rdf != '0), 64'(e.is_read));
            check("fin_grant_id", 64'(grant_id), 64'(e.idx));
            if (e.is_read) check("fin_readdata", 64'(rq.req_readdata), 64'(e.rdata));
            $display("[TB] txn req=%0d op=%s rdata=%08h", e.idx, e.is_read ? "RD" : "WR",
                     rq.req_readdata);
          end
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic set_req(input int idx, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rq.req_read[idx]  = rd;
    rq.req_write[idx] = wr;
    rq.req_addr[idx*ADDR_W +: ADDR_W]      = a;
    rq.req_writedata[idx*DATA_W +: DATA_W] = d;
  endtask

  task automatic drop_req(input int idx);
    rq.req_read[idx]  = 1'b0;
    rq.req_write[idx] = 1'b0;
  endtask

  task automatic push(input bit rd, input int idx, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rdata, input bit fin);
    bus_t b;
    fin_t e;
    b.is_read = rd; b.addr = a; b.wdata = d;
    exp_bus.push_back(b);
    if (fin) begin
      e.idx = idx; e.is_read = rd; e.rdata = rdata;
      exp_fin.push_back(e);
    end
  endtask

  // Bounded wait for any finished pulse; returns the pulsed index or -1.
  task automatic wait_fin(output int idx);
    logic [N_REQ-1:0] f;
    idx = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #2;
      f = rq.req_read_finished | rq.req_write_finished;
      if (f != '0) begin
        for (int i = 0; i < N_REQ; i++) if (f[i]) idx = i;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL wait_fin: got no finished pulse in 400 cycles, expected one");
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  int rr_order [6] = '{0, 1, 2, 3, 0, 1};

  // ---------------- Main sequence ----------------
  initial begin : stim
    int idx;
    int cnt;
    rq.req_read = '0; rq.req_write = '0; rq.req_addr = '0; rq.req_writedata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cs", 64'(cs), 64'h0);
    check("rst_read_n", 64'(rd_n), 64'h1);
    check("rst_write_n", 64'(wr_n), 64'h1);
    check("rst_be_n", 64'(be_n), 64'hF);
    check("rst_addr", 64'(av_addr), 64'h0);
    check("rst_wdata", 64'(av_wdata), 64'h0);
    check("rst_readdata", 64'(rq.req_readdata), 64'h0);
    check("rst_fin", 64'({rq.req_read_finished, rq.req_write_finished}), 64'h0);
    check("rst_grant", 64'(grant_id), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_timeout_err", 64'(timeout_err), 64'h0);
    rst = 1'b0;

    // Single write, no wait states
    stall_cfg = 0;
    @(negedge clk);
    push(1'b0, 0, 23'h000010, 32'hDEADBEEF, '0, 1'b1);
    set_req(0, 1'b0, 1'b1, 23'h000010, 32'hDEADBEEF);
    @(negedge clk); #2;
    check("wr_strobe_cs", 64'(cs), 64'h1);
    check("wr_strobe_write_n", 64'(wr_n), 64'h0);
    check("wr_strobe_addr", 64'(av_addr), 64'h10);
    check("wr_busy_c1", 64'(busy), 64'h1);
    @(negedge clk); #2;
    check("wr_fin_pulse", 64'(rq.req_write_finished), 64'h1);
    check("wr_busy_c2", 64'(busy), 64'h1);
    drop_req(0);
    @(negedge clk); #2;
    check("wr_fin_one_cycle", 64'(rq.req_write_finished), 64'h0);
    check("wr_busy_c3", 64'(busy), 64'h0);
    settle();

    // Read with 3 stall cycles, data 2 cycles after accept
    stall_cfg = 3; rd_lat_cfg = 2; rd_data_cfg = 32'h12345678;
    @(negedge clk);
    push(1'b1, 2, 23'h7FFFFF, '0, 32'h12345678, 1'b1);
    set_req(2, 1'b1, 1'b0, 23'h7FFFFF, 32'h0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #2;
      if (!rd_n) cnt++;
      if ((rq.req_read_finished | rq.req_write_finished) != '0) break;
    end
    check("rd_read_n_low_cycles", 64'(cnt), 64'd4);
    check("rd_fin_vector", 64'(rq.req_read_finished), 64'h4);
    check("rd_readdata", 64'(rq.req_readdata), 64'h12345678);
    drop_req(2);
    settle();

    // Read and write both set on requester 1: read wins
    stall_cfg = 0; rd_lat_cfg = 1; rd_data_cfg = 32'hA5A50001;
    @(negedge clk);
    push(1'b1, 1, 23'h0ABCDE, '0, 32'hA5A50001, 1'b1);
    set_req(1, 1'b1, 1'b1, 23'h0ABCDE, 32'h11111111);
    @(negedge clk); #2;
    check("both_read_n", 64'(rd_n), 64'h0);
    check("both_write_n", 64'(wr_n), 64'h1);
    wait_fin(idx);
    check("both_idx", 64'(idx), 64'd1);
    check("both_no_write_fin", 64'(rq.req_write_finished), 64'h0);
    drop_req(1);
    settle();

    // Write from 3; read data must hold its last value
    @(negedge clk);
    push(1'b0, 3, 23'h000333, 32'h33333333, '0, 1'b1);
    set_req(3, 1'b0, 1'b1, 23'h000333, 32'h33333333);
    wait_fin(idx);
    check("hold_readdata", 64'(rq.req_readdata), 64'hA5A50001);
    drop_req(3);
    settle();

    // Round-robin: all four keep requesting (pointer now at 3)
    stall_cfg = 1;
    @(negedge clk);
    for (int n = 0; n < 6; n++)
      push(1'b0, rr_order[n], ADDR_W'(32'h100 + rr_order[n]), 32'hC0DE0000 + rr_order[n], '0, 1'b1);
    for (int i = 0; i < N_REQ; i++)
      set_req(i, 1'b0, 1'b1, ADDR_W'(32'h100 + i), 32'hC0DE0000 + i);
    for (int n = 0; n < 6; n++) begin
      wait_fin(idx);
      check("rr_order", 64'(idx), 64'(rr_order[n]));
      if (idx < 0) break;
      drop_req(idx);
      if (n == 5) begin
        for (int i = 0; i < N_REQ; i++) drop_req(i);
      end else begin
        @(negedge clk);
        set_req(idx, 1'b0, 1'b1, ADDR_W'(32'h100 + idx), 32'hC0DE0000 + idx);
      end
    end
    settle();

    // Reset during WAIT_DATA; late readdatavalid must be ignored
    stall_cfg = 0; rd_lat_cfg = 5; rd_data_cfg = 32'hBAD0BAD0;
    @(negedge clk);
    push(1'b1, 2, 23'h000222, '0, '0, 1'b0);
    set_req(2, 1'b1, 1'b0, 23'h000222, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drop_req(2);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_cs", 64'(cs), 64'h0);
    check("midrst_read_n", 64'(rd_n), 64'h1);
    check("midrst_busy", 64'(busy), 64'h0);
    repeat (6) @(negedge clk);
    #2;
    check("midrst_readdata", 64'(rq.req_readdata), 64'h0);
    check("midrst_busy_after", 64'(busy), 64'h0);
    @(negedge clk);
    push(1'b0, 0, 23'h000200, 32'hA0, '0, 1'b1);
    push(1'b0, 3, 23'h000203, 32'hA3, '0, 1'b1);
    set_req(0, 1'b0, 1'b1, 23'h000200, 32'hA0);
    set_req(3, 1'b0, 1'b1, 23'h000203, 32'hA3);
    wait_fin(idx);
    check("postrst_first", 64'(idx), 64'd0);
    drop_req(0);
    wait_fin(idx);
    check("postrst_second", 64'(idx), 64'd3);
    drop_req(3);
    settle();

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Read that never returns data
    stall_cfg = 0; rd_lat_cfg = 0;
    @(negedge clk);
    push(1'b1, 1, 23'h000444, '0, 32'h0, 1'b1);
    set_req(1, 1'b1, 1'b0, 23'h000444, 32'h0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      cnt++;
      if (rq.req_read_finished != '0) break;
    end
    check("tmo_cycles", 64'(cnt), 64'd18);
    check("tmo_fin", 64'(rq.req_read_finished), 64'h2);
    check("tmo_readdata", 64'(rq.req_readdata), 64'h0);
    check("tmo_err_set", 64'(timeout_err), 64'h1);
    drop_req(1);
    settle();
    @(negedge clk);
    push(1'b0, 0, 23'h000555, 32'h55, '0, 1'b1);
    set_req(0, 1'b0, 1'b1, 23'h000555, 32'h55);
    wait_fin(idx);
    drop_req(0);
    settle();
    check("tmo_err_sticky", 64'(timeout_err), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("tmo_err_cleared", 64'(timeout_err), 64'h0);
`else
    check("no_tmo_err", 64'(timeout_err), 64'h0);
`endif

    settle();
    check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
    check("fin_queue_empty", 64'(exp_fin.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single Avalon-MM SDRAM controller slave (new_sdram_controller_0_s1) among the core's four masters: index 0 load, 1 record, 2 mix, 3 pitch. Sits between those cores and the SDRAM controller, replacing direct multi-driver hookup. Round-robin grant, one transaction in flight at a time. Each requester sees a read/write strobe interface with a one-cycle finished pulse.

Parameters:
N_REQ, 4, number of requesters (grant id width = $clog2(N_REQ))
ADDR_W, 23, SDRAM word address width
DATA_W, 32, SDRAM data width
TIMEOUT_CYCLES, 1024, read-data timeout (used only with SDRAM_ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
req_read  in  N_REQ  per-requester read request, level, held until finished
req_write  in  N_REQ  per-requester write request, level, held until finished
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_writedata  in  N_REQ*DATA_W  packed write data, same packing
req_readdata  out  DATA_W  shared read data, valid in cycle of a read_finished pulse
req_read_finished  out  N_REQ  one-cycle pulse to granted requester, read complete
req_write_finished  out  N_REQ  one-cycle pulse to granted requester, write complete
grant_id  out  $clog2(N_REQ)  currently/last granted requester
busy  out  1  high while not IDLE
timeout_err  out  1  sticky read-timeout flag
new_sdram_controller_0_s1_address  out  ADDR_W  Avalon address
new_sdram_controller_0_s1_byteenable_n  out  4  byte enables, active low
new_sdram_controller_0_s1_chipselect  out  1  chip select
new_sdram_controller_0_s1_writedata  out  DATA_W  write data
new_sdram_controller_0_s1_read_n  out  1  read strobe, active low
new_sdram_controller_0_s1_write_n  out  1  write strobe, active low
new_sdram_controller_0_s1_readdata  in  DATA_W  read data
new_sdram_controller_0_s1_readdatavalid  in  1  read data valid
new_sdram_controller_0_s1_waitrequest  in  1  slave stall

Behaviour:
- Single clock i_clk; i_rst synchronous active-high. Reset values: chipselect 0, read_n 1, write_n 1, byteenable_n 4'hF, address 0, writedata 0, req_readdata 0, all finished pulses 0, grant_id 0, busy 0, timeout_err 0, state IDLE, rr pointer last = N_REQ-1 (requester 0 served first).
- All outputs registered. FSM states: IDLE, ISSUE, WAIT_DATA, DONE.
- IDLE: pending[i] = req_read[i] | req_write[i]. If any pending, grant first pending index scanning last+1, last+2, ... modulo N_REQ; latch addr, writedata, op (read if req_read set, else write; both set -> read); last <= granted; -> ISSUE. Avalon strobes asserted from next cycle (request-to-strobe latency 1 cycle).
- ISSUE: chipselect 1, byteenable_n 0, read_n/write_n low per op, latched address/data. Hold stable while waitrequest=1. On waitrequest=0: write -> pulse req_write_finished[grant], -> DONE; read -> -> WAIT_DATA. Strobes deasserted on leaving ISSUE.
- WAIT_DATA: on readdatavalid=1 latch readdata into req_readdata, pulse req_read_finished[grant], -> DONE.
- DONE: one idle cycle; requests ignored (requester drops its level on seeing finished). -> IDLE. Min cycle per transaction: 3 (write, no wait), 4 + read latency (read).
- readdatavalid outside WAIT_DATA ignored. Request changes after grant have no effect on the in-flight transaction.
- req_readdata holds last read value until next read completes.
- Reset mid-transaction: next cycle all strobes deasserted, state IDLE, pointer reset; late readdatavalid ignored.
- Exactly one finished bit asserted per transaction, never both read and write.

Optional Feature:
SDRAM_ARB_TIMEOUT_EN: defined -> counter in WAIT_DATA; after TIMEOUT_CYCLES cycles with no readdatavalid, req_readdata <= 0, pulse req_read_finished[grant], set timeout_err (sticky until i_rst), -> DONE. Undefined -> WAIT_DATA waits indefinitely; timeout_err tied 0; no counter logic.

Test Plan:
- Single write: req_write[0]=1, addr 0x000010, data 0xDEADBEEF, waitrequest 0 -> cycle+1 chipselect=1, write_n=0, address 0x10, writedata 0xDEADBEEF; req_write_finished[0] pulses 1 cycle; busy low 3 cycles after request.
- Read with stall: req_read[2]=1 addr 0x7FFFFF, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with 0x12345678 -> read_n held low 4 cycles, address stable; req_readdata=0x12345678 with req_read_finished[2] pulse.
- Round-robin: all four requesting continuously (dropping/reasserting after finish) -> grant order 0,1,2,3,0,1; no requester granted twice before others.
- Both req_read[1] and req_write[1] set -> read issued (read_n=0, write_n=1), only req_read_finished[1] pulses.
- Reset mid-read: i_rst during WAIT_DATA then readdatavalid -> no finished pulse, strobes deasserted, next grant goes to requester 0.
- SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no readdatavalid -> after 16 cycles req_read_finished pulse, req_readdata=0, timeout_err=1 until reset.
